// File: rtl/truth_table_sweeper_pkg.sv
// sweep_pkg: shared state encoding and width helpers for the truth-table sweeper.
package sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_REPORT,
        S_DONE
    } sweep_state_t;

    function automatic int err_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: per-row log record channel with valid/ready handshake.
interface truth_table_sweeper_if #(
    parameter int N_IN = 2
);
    logic            log_valid;
    logic            log_ready;
    logic [N_IN-1:0] log_vec;
    logic            log_dut;
    logic            log_exp;

    modport master (output log_valid, log_vec, log_dut, log_exp, input log_ready);
    modport slave  (input log_valid, log_vec, log_dut, log_exp, output log_ready);
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// sweep_settle_timer: counts cycles a combination has been held; expired on the last settle cycle.
module sweep_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = SETTLE > 1 ? $clog2(SETTLE) : 1;

    logic [W-1:0] count;

    assign expired = count == W'(SETTLE - 1);

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every DUT input combination, samples DUT vs golden output, logs each row.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic [N_IN-1:0]             stim,
    input  logic                        dut_out,
    input  logic                        exp_out,
    output logic                        busy,
    output logic                        done,
    truth_table_sweeper_if.master       log_bus,
    output logic [err_width(N_IN)-1:0]  err_count,
    output logic                        first_err_valid,
    output logic [N_IN-1:0]             first_err_vec
);
    sweep_state_t state, nxt;
    logic         expired;
    logic         last;

    assign last = &stim;
    assign busy = state == S_SETTLE || state == S_REPORT;
    assign done = state == S_DONE;

    sweep_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != S_SETTLE),
        .enable (state == S_SETTLE),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = start ? S_SETTLE : S_IDLE;
            S_SETTLE: nxt = expired ? S_REPORT : S_SETTLE;
            S_REPORT: nxt = log_bus.log_ready ? (last ? S_DONE : S_SETTLE) : S_REPORT;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stim              <= '0;
            log_bus.log_valid <= 1'b0;
            log_bus.log_vec   <= '0;
            log_bus.log_dut   <= 1'b0;
            log_bus.log_exp   <= 1'b0;
            err_count         <= '0;
            first_err_valid   <= 1'b0;
            first_err_vec     <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                stim            <= '0;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_vec   <= '0;
            end
            if (state == S_SETTLE && expired) begin
                log_bus.log_valid <= 1'b1;
                log_bus.log_vec   <= stim;
                log_bus.log_dut   <= dut_out;
                log_bus.log_exp   <= exp_out;
                if (dut_out != exp_out) begin
                    err_count <= err_count + 1'b1;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= stim;
                    end
                end
            end
            // last row exits to DONE, so stim never wraps back to zero
            if (state == S_REPORT && log_bus.log_ready) begin
                log_bus.log_valid <= 1'b0;
                if (!last)
                    stim <= stim + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed and randomized sweeps of two sweeper instances (SETTLE=1 and SETTLE=3).
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic reset, start, ready, sel;
    int   mode;
    logic [3:0] fault;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(2)) lb1 ();
    truth_table_sweeper_if #(.N_IN(2)) lb2 ();

    logic [1:0] stim1, stim2, fvec1, fvec2;
    logic [2:0] ec1, ec2;
    logic       dut1, exp1, dut2, exp2, busy1, busy2, done1, done2, fev1, fev2;
    logic       start1, start2;

    assign start1 = start & ~sel;
    assign start2 = start & sel;
    assign lb1.log_ready = ready;
    assign lb2.log_ready = ready;

    // DUT network under test: De Morgan AND form, optionally stuck at 0 or with per-row faults
    assign dut1 = (mode == 1) ? 1'b0 : ((~stim1[1] & ~stim1[0]) ^ (mode == 2 && fault[stim1]));
    assign exp1 = ~(stim1[1] | stim1[0]);
    assign dut2 = (mode == 1) ? 1'b0 : ((~stim2[1] & ~stim2[0]) ^ (mode == 2 && fault[stim2]));
    assign exp2 = ~(stim2[1] | stim2[0]);

    truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .stim(stim1),
        .dut_out(dut1), .exp_out(exp1), .busy(busy1), .done(done1),
        .log_bus(lb1), .err_count(ec1), .first_err_valid(fev1), .first_err_vec(fvec1)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(3)) u2 (
        .clk(clk), .reset(reset), .start(start2), .stim(stim2),
        .dut_out(dut2), .exp_out(exp2), .busy(busy2), .done(done2),
        .log_bus(lb2), .err_count(ec2), .first_err_valid(fev2), .first_err_vec(fvec2)
    );

    logic [1:0] o_stim, o_vec, o_fvec;
    logic [2:0] o_ec;
    logic       o_busy, o_done, o_valid, o_dut, o_exp, o_fev;

    assign o_stim  = sel ? stim2 : stim1;
    assign o_busy  = sel ? busy2 : busy1;
    assign o_done  = sel ? done2 : done1;
    assign o_valid = sel ? lb2.log_valid : lb1.log_valid;
    assign o_vec   = sel ? lb2.log_vec : lb1.log_vec;
    assign o_dut   = sel ? lb2.log_dut : lb1.log_dut;
    assign o_exp   = sel ? lb2.log_exp : lb1.log_exp;
    assign o_ec    = sel ? ec2 : ec1;
    assign o_fev   = sel ? fev2 : fev1;
    assign o_fvec  = sel ? fvec2 : fvec1;

    // reference: golden output is NOR, i.e. high only for the all-zero row
    function automatic bit m_exp(input int v);
        return v == 0;
    endfunction

    function automatic bit m_dut(input int v);
        if (mode == 1) return 1'b0;
        return (v == 0) ^ (mode == 2 && fault[v]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic sweep(input bit bp_dir, input bit poke);
        int s;
        int stall;
        int errs;
        int first;
        s = sel ? 3 : 1;
        errs = 0;
        first = -1;
        start = 1'b1;
        ready = $urandom_range(0, 1) != 0;
        step();
        start = 1'b0;
        chk("busy_on", 32'(o_busy), 1);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < s; i++) begin
                chk("settle_valid", 32'(o_valid), 0);
                chk("settle_stim", 32'(o_stim), r);
                chk("settle_busy", 32'(o_busy), 1);
                ready = $urandom_range(0, 1) != 0;
                if (poke) start = $urandom_range(0, 1) != 0;
                step();
            end
            chk("rec_valid", 32'(o_valid), 1);
            chk("rec_vec", 32'(o_vec), r);
            chk("rec_dut", 32'(o_dut), 32'(m_dut(r)));
            chk("rec_exp", 32'(o_exp), 32'(m_exp(r)));
            chk("rec_done", 32'(o_done), 0);
            stall = bp_dir ? (r == 2 ? 5 : 0) : $urandom_range(0, 3);
            for (int i = 0; i < stall; i++) begin
                ready = 1'b0;
                if (poke) start = $urandom_range(0, 1) != 0;
                step();
                chk("bp_valid", 32'(o_valid), 1);
                chk("bp_vec", 32'(o_vec), r);
                chk("bp_stim", 32'(o_stim), r);
            end
            ready = 1'b1;
            step();
            start = 1'b0;
            if (m_dut(r) != m_exp(r)) begin
                errs++;
                if (first < 0) first = r;
            end
        end
        chk("done_hi", 32'(o_done), 1);
        chk("busy_off", 32'(o_busy), 0);
        chk("valid_off", 32'(o_valid), 0);
        chk("end_stim", 32'(o_stim), 3);
        chk("err_count", 32'(o_ec), errs);
        chk("first_valid", 32'(o_fev), 32'(first >= 0));
        chk("first_vec", 32'(o_fvec), first < 0 ? 0 : first);
        ready = $urandom_range(0, 1) != 0;
        step();
        chk("done_pulse", 32'(o_done), 0);
        chk("err_persist", 32'(o_ec), errs);
        chk("stim_hold", 32'(o_stim), 3);
    endtask

    task automatic chk_reset_vals();
        chk("rst_stim", 32'(o_stim), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_vec", 32'(o_vec), 0);
        chk("rst_dut", 32'(o_dut), 0);
        chk("rst_exp", 32'(o_exp), 0);
        chk("rst_ec", 32'(o_ec), 0);
        chk("rst_fev", 32'(o_fev), 0);
        chk("rst_fvec", 32'(o_fvec), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        sel = 1'b0;
        mode = 0;
        fault = 4'h0;
        step();
        step();
        reset = 1'b0;
        chk_reset_vals();
        sel = 1'b1;
        chk_reset_vals();
        sel = 1'b0;

        sweep(1'b0, 1'b0);
        mode = 1;
        sweep(1'b0, 1'b0);
        mode = 0;
        sweep(1'b1, 1'b0);

        sel = 1'b1;
        sweep(1'b0, 1'b0);
        mode = 2;
        fault = 4'($urandom);
        sweep(1'b0, 1'b0);
        sel = 1'b0;

        mode = 1;
        start = 1'b1;
        ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mid_stim", 32'(o_stim), 1);
        chk("mid_ec", 32'(o_ec), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals();
        sweep(1'b0, 1'b0);

        mode = 2;
        for (int k = 0; k < 4; k++) begin
            fault = 4'($urandom) | 4'h1;
            sweep(1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
